// File: rtl/audio_pkg.sv
// Shared audio constants for the DAC serializer, tone generators and codec
// configuration blocks.
//   SAMPLE_W          bits per channel sample and per LRCK half-frame
//   SLOTS_PER_FRAME   BCLK slots per LRCK frame (left + right)
//   HALF_BCLK_DEFAULT CLOCK_50 cycles per AUD_BCLK half-period
package audio_pkg;

    localparam int unsigned SAMPLE_W          = 32;
    localparam int unsigned SLOTS_PER_FRAME   = 2 * SAMPLE_W;
    localparam int unsigned HALF_BCLK_DEFAULT = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock divider for the audio DAC serializer.
//   CLOCK_50  in   system clock
//   reset     in   synchronous, active-high reset
//   bclk      out  codec bit clock, high out of reset
//   fall      out  strobe, high in the cycle whose closing edge drives bclk 1->0
module bclk_divider
    import audio_pkg::*;
#(
    parameter int unsigned HALF_BCLK = HALF_BCLK_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic bclk,
    output logic fall
);

    localparam logic [7:0] TermCnt = 8'(HALF_BCLK - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       bclk_q, bclk_d;
    logic       term;

    always_comb begin
        term   = (cnt_q == TermCnt);
        cnt_d  = term ? 8'd0 : cnt_q + 8'd1;
        bclk_d = term ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q  <= 8'd0;
            bclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    // Combinational so serial state updates on the same edge that drops bclk.
    assign fall = term & bclk_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified, MSB-first stereo serializer for a slave codec DAC.
//   CLOCK_50      in   system clock
//   reset         in   synchronous, active-high reset
//   sample_l/r    in   signed left/right samples offered upstream
//   sample_valid  in   upstream offers a sample pair this cycle
//   sample_ready  out  one-entry holding register is empty
//   AUD_BCLK      out  codec bit clock
//   AUD_DACLRCK   out  frame clock, high = left slot
//   AUD_DACDAT    out  serial data
//   underrun      out  one-cycle pulse when a frame starts with nothing new held
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int unsigned HALF_BCLK = HALF_BCLK_DEFAULT,
    parameter int unsigned SAMPLE_W  = audio_pkg::SAMPLE_W
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                underrun
);

    localparam int unsigned SLOT_W = $clog2(2 * SAMPLE_W);
    localparam int unsigned SR_W   = 2 * SAMPLE_W;

    logic                fall;
    logic                frame_start;
    logic                accept;

    logic [SLOT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                lrck_q, lrck_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic                underrun_q, underrun_d;

    bclk_divider #(
        .HALF_BCLK (HALF_BCLK)
    ) u_bclk_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bclk     (AUD_BCLK),
        .fall     (fall)
    );

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        sr_d        = sr_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        last_l_d    = last_l_q;
        last_r_d    = last_r_q;
        underrun_d  = 1'b0;

        accept      = sample_valid & ~hold_full_q;
        // Slot counter sits at its last slot out of reset, so the first fall starts a frame.
        frame_start = fall & (bit_cnt_q == '1);

        if (fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            lrck_d    = ~bit_cnt_d[SLOT_W-1];
            if (frame_start) begin
                if (hold_full_q) begin
                    sr_d        = {hold_l_q, hold_r_q};
                    last_l_d    = hold_l_q;
                    last_r_d    = hold_r_q;
                    hold_full_d = 1'b0;
                end else begin
                    sr_d       = {last_l_q, last_r_q};
                    underrun_d = 1'b1;
                end
            end else begin
                sr_d = {sr_q[SR_W-2:0], 1'b0};
            end
        end

        // Accept needs an empty hold, so it never collides with the frame-start drain above;
        // a sample accepted on a frame-start cycle waits for the following frame.
        if (accept) begin
            hold_l_d    = sample_l;
            hold_r_d    = sample_r;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt_q   <= '1;
            lrck_q      <= 1'b0;
            sr_q        <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            last_l_q    <= '0;
            last_r_q    <= '0;
            underrun_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            sr_q        <= sr_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            last_l_q    <= last_l_d;
            last_r_q    <= last_r_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign AUD_DACLRCK  = lrck_q;
    assign AUD_DACDAT   = sr_q[SR_W-1];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized scoreboard bench for audio_dac_serializer at the default divider.
module tb_audio_dac_serializer;

    localparam int unsigned HB    = 8;
    localparam int unsigned BIT_T = 2 * HB;      // cycles per slot
    localparam int unsigned FRAME = 64 * BIT_T;  // cycles per frame
    localparam int unsigned FIRST = HB;          // edge index of the first bclk fall

    localparam logic [31:0] POS = 32'd10_000_000;
    localparam logic [31:0] NEG = 32'hFF67_6980;  // -10_000_000

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sample_l = '0;
    logic [31:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        underrun;

    audio_dac_serializer #(
        .HALF_BCLK (HB),
        .SAMPLE_W  (32)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .underrun     (underrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [63:0] word;
        bit          under;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned t = 0;            // clock edges since the last reset edge
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          m_hold_full = 1'b0;
    logic [63:0] m_hold = '0;
    logic [63:0] m_last = '0;
    bit          m_acc = 1'b0;

    function automatic bit is_fs(input int unsigned x);
        return (x >= FIRST) && ((x - FIRST) % FRAME == 0);
    endfunction

    // Reference model: one-entry mailbox feeding one frame per FRAME cycles.
    task automatic model_edge(input bit rst, input bit v, input logic [31:0] l,
                              input logic [31:0] r);
        frame_t f;
        if (rst) begin
            t           = 0;
            m_hold_full = 1'b0;
            m_hold      = '0;
            m_last      = '0;
            m_acc       = 1'b0;
            exp_q.delete();
            return;
        end
        t++;
        m_acc = v && !m_hold_full;
        if (is_fs(t)) begin
            if (m_hold_full) begin
                f.word      = m_hold;
                f.under     = 1'b0;
                m_last      = m_hold;
                m_hold_full = 1'b0;
            end else begin
                f.word  = m_last;
                f.under = 1'b1;
            end
            exp_q.push_back(f);
        end
        if (m_acc) begin
            m_hold      = {l, r};
            m_hold_full = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [31:0] l, input logic [31:0] r);
        reset        = rst;
        sample_valid = v;
        sample_l     = l;
        sample_r     = r;
        @(posedge CLOCK_50);
        model_edge(rst, v, l, r);
        #1;
    endtask

    // Monitor: pops a frame when LRCK rises, then checks every output each cycle.
    initial begin
        logic [63:0] cur;
        bit          cur_ur;
        logic        prev_lrck;
        logic [4:0]  got, exp;
        int unsigned s;
        bit          lrck_e, dat_e, ur_e;
        frame_t      f;
        cur       = '0;
        cur_ur    = 1'b0;
        prev_lrck = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (t == 0) begin
                cur    = '0;
                cur_ur = 1'b0;
            end else if (AUD_DACLRCK && !prev_lrck) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_pop: LRCK rose at t=%0d, got a frame, expected none", t);
                end else begin
                    f      = exp_q.pop_front();
                    cur    = f.word;
                    cur_ur = f.under;
                end
            end
            prev_lrck = AUD_DACLRCK;

            if (t < FIRST) begin
                lrck_e = 1'b0;
                dat_e  = 1'b0;
            end else begin
                s      = ((t - FIRST) / BIT_T) % 64;
                lrck_e = (s < 32);
                dat_e  = cur[63-s];
            end
            ur_e = is_fs(t) ? cur_ur : 1'b0;
            exp  = {((t / HB) % 2) == 0, lrck_e, dat_e, !m_hold_full, ur_e};
            got  = {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_ready, underrun};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs t=%0d {bclk,lrck,dat,ready,underrun}: got %b expected %b",
                         t, got, exp);
            end
        end
    end

    initial begin
        bit pos;
        int unsigned dens;

        // Idle after reset: zero frames with an underrun at every frame start.
        repeat (3) step(1'b1, 1'b0, '0, '0);
        repeat (2 * FRAME + 100) step(1'b0, 1'b0, '0, '0);

        // Sample accepted before the first frame carries the extreme bit patterns.
        repeat (2) step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFE);
        repeat (FRAME + 50) step(1'b0, 1'b0, '0, '0);

        // Valid tied high, value flips after every accepted transfer.
        pos = 1'b1;
        repeat (4 * FRAME) begin
            step(1'b0, 1'b1, pos ? POS : NEG, pos ? NEG : POS);
            if (m_acc) pos = ~pos;
        end

        // Random data with varying offer density; held samples see changing offers.
        for (int b = 0; b < 6; b++) begin
            dens = (b % 3 == 0) ? 2 : ((b % 3 == 1) ? 300 : 1);
            repeat (FRAME) step(1'b0, $urandom_range(0, 1023) < dens, $urandom, $urandom);
        end

        // Offer exactly on a frame-start edge with the hold empty.
        repeat (FRAME + 20) step(1'b0, 1'b0, '0, '0);
        while (!is_fs(t + 1)) step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (2 * FRAME + 40) step(1'b0, 1'b0, '0, '0);

        // Reset in the middle of slot 40, with offers during reset that must be ignored.
        while (!m_hold_full) step(1'b0, 1'b1, $urandom, $urandom);
        while (!(t >= FIRST && (t - FIRST) % FRAME == 40 * BIT_T + 5))
            step(1'b0, 1'b0, '0, '0);
        repeat (3) step(1'b1, 1'b1, $urandom, $urandom);
        step(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        repeat (2 * FRAME + 40) step(1'b0, 1'b0, '0, '0);

        @(negedge CLOCK_50);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
